// File: rtl/rtc_bus_pkg.sv
// ============================================================================
// Module : rtc_bus_pkg
// Brief  : Shared RTC bus addresses, field indices and bus-engine state encoding.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package rtc_bus_pkg;

  localparam logic [7:0] c_A_FMT  = 8'h00;
  localparam logic [7:0] c_A_INI  = 8'h02;
  localparam logic [7:0] c_A_SEC  = 8'h21;
  localparam logic [7:0] c_A_MIN  = 8'h22;
  localparam logic [7:0] c_A_HOUR = 8'h23;
  localparam logic [7:0] c_A_DAY  = 8'h24;
  localparam logic [7:0] c_A_MON  = 8'h25;
  localparam logic [7:0] c_A_YEAR = 8'h26;

  typedef enum logic [2:0] {
    F_SEC  = 3'd0,
    F_MIN  = 3'd1,
    F_HOUR = 3'd2,
    F_DAY  = 3'd3,
    F_MON  = 3'd4,
    F_YEAR = 3'd5
  } field_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_A_SET = 3'd1,
    S_A_STB = 3'd2,
    S_A_HLD = 3'd3,
    S_D_SET = 3'd4,
    S_D_STB = 3'd5,
    S_D_HLD = 3'd6,
    S_DONE  = 3'd7
  } state_t;

  // Lowest set bit wins, so seconds has the highest priority.
  function automatic field_e lowest_field(input logic [5:0] sel);
    if (sel[0])      lowest_field = F_SEC;
    else if (sel[1]) lowest_field = F_MIN;
    else if (sel[2]) lowest_field = F_HOUR;
    else if (sel[3]) lowest_field = F_DAY;
    else if (sel[4]) lowest_field = F_MON;
    else if (sel[5]) lowest_field = F_YEAR;
    else             lowest_field = F_SEC;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rtc_phase_timer.sv
// ============================================================================
// Module : rtc_phase_timer
// Brief  : Down-counter timing one bus phase of PHASE_CYC clocks.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rtc_phase_timer #(
  parameter int PHASE_CYC = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  output logic o_last
);

  localparam int c_CNT_W = $clog2(PHASE_CYC + 1);

  logic [c_CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= c_CNT_W'(PHASE_CYC - 1);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_last = (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/rtc_bus_engine.sv
// ============================================================================
// Module : rtc_bus_engine
// Brief  : Runs RTC init/format/write/read requests as multiplexed A/D bus cycles.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rtc_bus_engine
  import rtc_bus_pkg::*;
#(
  parameter int         PHASE_CYC = 4,
  parameter logic [7:0] A_FMT     = c_A_FMT,
  parameter logic [7:0] A_INI     = c_A_INI,
  parameter logic [7:0] A_SEC     = c_A_SEC
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enini,
  input  logic       cfgfmt,
  input  logic       enwrite,
  input  logic       enread,
  input  logic [5:0] sel,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] rsec,
  output logic [7:0] rmin,
  output logic [7:0] rhour,
  output logic [7:0] rday,
  output logic [7:0] rmon,
  output logic [7:0] ryear,
  output logic       cs_n,
  output logic       ad_n,
  output logic       wr_n,
  output logic       rd_n,
  output logic [7:0] ad_o,
  output logic       ad_oe,
  input  logic [7:0] ad_i
);

  state_t     r_state, w_state_nxt;
  logic [7:0] r_addr, r_wdata, r_rdata;
  logic       r_dir;
  field_e     r_field;
  logic       r_armed, r_err;
  logic [7:0] r_sec, r_min, r_hour, r_day, r_mon, r_year;

  logic       w_req_any, w_accept, w_reject, w_load, w_last, w_dir;
  logic [7:0] w_addr;
  field_e     w_sel_field;

  rtc_phase_timer #(
    .PHASE_CYC (PHASE_CYC)
  ) u_timer (
    .clk    (clk),
    .rst_n  (reset),
    .i_load (w_load),
    .o_last (w_last)
  );

  always_comb begin
    w_req_any   = enini | cfgfmt | enwrite | enread;
    w_sel_field = lowest_field(sel);
    w_accept    = 1'b0;
    w_reject    = 1'b0;
    w_load      = 1'b0;
    w_dir       = 1'b0;
    w_state_nxt = r_state;
    if (enini) begin
      w_addr = A_INI;
    end else if (cfgfmt) begin
      w_addr = A_FMT;
    end else begin
      w_addr = A_SEC + 8'(w_sel_field);
      w_dir  = ~enwrite;
    end
    case (r_state)
      S_IDLE: begin
        if (r_armed && w_req_any) begin
          if (enini || cfgfmt || (sel != 6'd0)) begin
            w_accept    = 1'b1;
            w_load      = 1'b1;
            w_state_nxt = S_A_SET;
          end else begin
            w_reject = 1'b1;
          end
        end
      end
      S_A_SET: if (w_last) begin w_state_nxt = S_A_STB; w_load = 1'b1; end
      S_A_STB: if (w_last) begin w_state_nxt = S_A_HLD; w_load = 1'b1; end
      S_A_HLD: if (w_last) begin w_state_nxt = S_D_SET; w_load = 1'b1; end
      S_D_SET: if (w_last) begin w_state_nxt = S_D_STB; w_load = 1'b1; end
      S_D_STB: if (w_last) begin w_state_nxt = S_D_HLD; w_load = 1'b1; end
      S_D_HLD: if (w_last) begin w_state_nxt = S_DONE;  w_load = 1'b1; end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Bus pins decode straight from registered state, so reset releases them at once.
  always_comb begin
    cs_n  = 1'b1;
    ad_n  = 1'b1;
    wr_n  = 1'b1;
    rd_n  = 1'b1;
    ad_oe = 1'b0;
    ad_o  = 8'h00;
    busy  = 1'b0;
    done  = 1'b0;
    case (r_state)
      S_A_SET, S_A_STB, S_A_HLD: begin
        cs_n  = 1'b0;
        ad_n  = 1'b0;
        ad_oe = 1'b1;
        ad_o  = r_addr;
        busy  = 1'b1;
        wr_n  = (r_state != S_A_STB);
      end
      S_D_SET, S_D_STB, S_D_HLD: begin
        cs_n = 1'b0;
        busy = 1'b1;
        if (!r_dir) begin
          ad_oe = 1'b1;
          ad_o  = r_wdata;
          wr_n  = (r_state != S_D_STB);
        end else begin
          rd_n  = (r_state != S_D_STB);
        end
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_addr  <= 8'h00;
      r_wdata <= 8'h00;
      r_rdata <= 8'h00;
      r_dir   <= 1'b0;
      r_field <= F_SEC;
      r_armed <= 1'b1;
      r_err   <= 1'b0;
      r_sec   <= 8'h00;
      r_min   <= 8'h00;
      r_hour  <= 8'h00;
      r_day   <= 8'h00;
      r_mon   <= 8'h00;
      r_year  <= 8'h00;
    end else begin
      r_state <= w_state_nxt;
      r_err   <= w_reject;
      if (!w_req_any) begin
        r_armed <= 1'b1;
      end else if (w_accept || w_reject) begin
        r_armed <= 1'b0;
      end
      if (w_accept) begin
        r_addr  <= w_addr;
        r_wdata <= wdata;
        r_dir   <= w_dir;
        r_field <= w_sel_field;
      end
      if ((r_state == S_D_STB) && w_last && r_dir) begin
        r_rdata <= ad_i;
      end
      if ((r_state == S_DONE) && r_dir) begin
        case (r_field)
          F_SEC:   r_sec  <= r_rdata;
          F_MIN:   r_min  <= r_rdata;
          F_HOUR:  r_hour <= r_rdata;
          F_DAY:   r_day  <= r_rdata;
          F_MON:   r_mon  <= r_rdata;
          F_YEAR:  r_year <= r_rdata;
          default: ;
        endcase
      end
    end
  end

  assign err   = r_err;
  assign rsec  = r_sec;
  assign rmin  = r_min;
  assign rhour = r_hour;
  assign rday  = r_day;
  assign rmon  = r_mon;
  assign ryear = r_year;

endmodule

`default_nettype wire

// File: tb/tb_rtc_bus_engine.sv
// ============================================================================
// Module : tb_rtc_bus_engine
// Brief  : Vector table, hand sequences and random requests against a transaction model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rtc_bus_engine;

  localparam int PHASE_CYC = 2;

  typedef struct {
    bit       ini, fmt, wr, rd;
    bit [5:0] sel;
    bit [7:0] wdata, rdbyte;
    bit       e_err;
    bit [7:0] e_addr;
    bit       e_rd;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enini = 1'b0, cfgfmt = 1'b0, enwrite = 1'b0, enread = 1'b0;
  logic [5:0] sel = 6'd0;
  logic [7:0] wdata = 8'h00, ad_i = 8'h00;
  logic       busy, done, err, cs_n, ad_n, wr_n, rd_n, ad_oe;
  logic [7:0] rsec, rmin, rhour, rday, rmon, ryear, ad_o;

  int n_vec = 0, n_fail = 0;
  int m_cs = 0, m_aw = 0, m_dw = 0, m_rd = 0, m_oe_rd = 0, m_cont = 0, m_done = 0;
  logic [7:0] m_addr = 8'h00, m_data = 8'h00;
  bit cur_is_read = 1'b0;
  bit [7:0] exp_r [6];
  vec_t tbl [10];

  rtc_bus_engine #(.PHASE_CYC(PHASE_CYC)) dut (
    .clk(clk), .reset(reset), .enini(enini), .cfgfmt(cfgfmt), .enwrite(enwrite),
    .enread(enread), .sel(sel), .wdata(wdata), .busy(busy), .done(done), .err(err),
    .rsec(rsec), .rmin(rmin), .rhour(rhour), .rday(rday), .rmon(rmon), .ryear(ryear),
    .cs_n(cs_n), .ad_n(ad_n), .wr_n(wr_n), .rd_n(rd_n), .ad_o(ad_o), .ad_oe(ad_oe),
    .ad_i(ad_i)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset) begin
      if (!cs_n) m_cs++;
      if (!cs_n && !ad_n && !wr_n) begin m_aw++; m_addr = ad_o; end
      if (!cs_n && ad_n && !wr_n) begin m_dw++; m_data = ad_o; end
      if (!cs_n && ad_n && !rd_n) m_rd++;
      if (!cs_n && ad_n && ad_oe && cur_is_read) m_oe_rd++;
      if (ad_oe && !rd_n) m_cont++;
      if (done) m_done++;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_regs();
    chk("rsec", {24'd0, rsec}, {24'd0, exp_r[0]});
    chk("rmin", {24'd0, rmin}, {24'd0, exp_r[1]});
    chk("rhour", {24'd0, rhour}, {24'd0, exp_r[2]});
    chk("rday", {24'd0, rday}, {24'd0, exp_r[3]});
    chk("rmon", {24'd0, rmon}, {24'd0, exp_r[4]});
    chk("ryear", {24'd0, ryear}, {24'd0, exp_r[5]});
  endtask

  function automatic vec_t mkv(bit ini, bit fmt, bit wr, bit rd, bit [5:0] s, bit [7:0] wd,
                               bit [7:0] rb, bit ee, bit [7:0] ea, bit er);
    vec_t v;
    v.ini = ini; v.fmt = fmt; v.wr = wr; v.rd = rd; v.sel = s; v.wdata = wd; v.rdbyte = rb;
    v.e_err = ee; v.e_addr = ea; v.e_rd = er;
    return v;
  endfunction

  // Transaction-level reference: which bus access a request set should produce.
  function automatic vec_t model(vec_t v);
    vec_t r = v;
    r.e_err = 1'b0; r.e_rd = 1'b0; r.e_addr = 8'h00;
    if (v.ini) r.e_addr = 8'h02;
    else if (v.fmt) r.e_addr = 8'h00;
    else begin
      r.e_rd = !v.wr;
      if (v.sel == 6'd0) r.e_err = 1'b1;
      else begin
        for (int i = 5; i >= 0; i--) if (v.sel[i]) r.e_addr = 8'h21 + 8'(i);
      end
    end
    return r;
  endfunction

  task automatic run_vec(input vec_t v);
    int s_cs, s_aw, s_dw, s_rd, s_oe, s_ct, s_dn, n;
    bit got;
    s_cs = m_cs; s_aw = m_aw; s_dw = m_dw; s_rd = m_rd; s_oe = m_oe_rd; s_ct = m_cont; s_dn = m_done;
    @(negedge clk);
    enini = v.ini; cfgfmt = v.fmt; enwrite = v.wr; enread = v.rd;
    sel = v.sel; wdata = v.wdata; ad_i = v.rdbyte; cur_is_read = v.e_rd;
    if (v.e_err) begin
      @(posedge clk); #1;
      chk("err_pulse", {31'd0, err}, 32'd1);
      chk("err_busy", {31'd0, busy}, 32'd0);
      @(posedge clk); #1;
      chk("err_width", {31'd0, err}, 32'd0);
    end else begin
      n = 0; got = 1'b0;
      while (!got && n < 100) begin
        @(posedge clk); n++; #1;
        if (n == 1) chk("busy_on_accept", {31'd0, busy}, 32'd1);
        if (done) got = 1'b1;
      end
      chk("latency", n, 6 * PHASE_CYC + 1);
      chk("busy_with_done", {31'd0, busy}, 32'd0);
    end
    repeat (4) @(posedge clk);
    @(negedge clk);
    enini = 1'b0; cfgfmt = 1'b0; enwrite = 1'b0; enread = 1'b0;
    @(negedge clk);
    chk("cs_cycles", m_cs - s_cs, v.e_err ? 0 : 6 * PHASE_CYC);
    chk("done_pulses", m_done - s_dn, v.e_err ? 0 : 1);
    chk("contention", m_cont - s_ct, 0);
    if (!v.e_err) begin
      chk("addr_strobe", m_aw - s_aw, PHASE_CYC);
      chk("addr_value", {24'd0, m_addr}, {24'd0, v.e_addr});
      if (v.e_rd) begin
        chk("rd_strobe", m_rd - s_rd, PHASE_CYC);
        chk("oe_in_read", m_oe_rd - s_oe, 0);
        chk("wr_in_read", m_dw - s_dw, 0);
        exp_r[v.e_addr - 8'h21] = v.rdbyte;
      end else begin
        chk("data_strobe", m_dw - s_dw, PHASE_CYC);
        chk("data_value", {24'd0, m_data}, {24'd0, v.wdata});
        chk("rd_in_write", m_rd - s_rd, 0);
      end
    end
    check_regs();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int n;
    for (int i = 0; i < 6; i++) exp_r[i] = 8'h00;
    tbl[0] = mkv(0, 0, 1, 0, 6'b000100, 8'h12, 8'h00, 0, 8'h23, 0);
    tbl[1] = mkv(0, 0, 0, 1, 6'b000001, 8'h00, 8'h59, 0, 8'h21, 1);
    tbl[2] = mkv(1, 0, 1, 0, 6'b000100, 8'h01, 8'h00, 0, 8'h02, 0);
    tbl[3] = mkv(0, 0, 1, 0, 6'b000100, 8'h01, 8'h00, 0, 8'h23, 0);
    tbl[4] = mkv(0, 0, 0, 1, 6'b000000, 8'h00, 8'h77, 1, 8'h00, 1);
    tbl[5] = mkv(0, 0, 0, 1, 6'b100010, 8'h00, 8'h3A, 0, 8'h22, 1);
    tbl[6] = mkv(0, 1, 0, 1, 6'b000001, 8'h40, 8'h11, 0, 8'h00, 0);
    tbl[7] = mkv(0, 0, 1, 0, 6'b100000, 8'h99, 8'h00, 0, 8'h26, 0);
    tbl[8] = mkv(0, 0, 0, 1, 6'b100000, 8'h00, 8'h24, 0, 8'h26, 1);
    tbl[9] = mkv(0, 0, 1, 0, 6'b000000, 8'h55, 8'h00, 1, 8'h00, 0);

    #3;
    chk("rst_cs_n", {31'd0, cs_n}, 32'd1);
    chk("rst_strobes", {29'd0, ad_n, wr_n, rd_n}, 32'd7);
    chk("rst_ad_oe", {31'd0, ad_oe}, 32'd0);
    chk("rst_ad_o", {24'd0, ad_o}, 32'd0);
    chk("rst_flags", {29'd0, busy, done, err}, 32'd0);
    check_regs();
    repeat (2) @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 10; i++) run_vec(tbl[i]);

    // Reset during the data strobe of a write.
    @(negedge clk);
    enwrite = 1'b1; sel = 6'b000001; wdata = 8'hA5;
    n = 0;
    while (!(cs_n == 1'b0 && ad_n == 1'b1 && wr_n == 1'b0) && n < 100) begin
      @(posedge clk); n++; #1;
    end
    chk("reach_d_stb", {31'd0, n < 100}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("rst_mid_strobes", {28'd0, cs_n, ad_n, wr_n, rd_n}, 32'hF);
    chk("rst_mid_ad_oe", {31'd0, ad_oe}, 32'd0);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    enwrite = 1'b0; sel = 6'd0;
    for (int i = 0; i < 6; i++) exp_r[i] = 8'h00;
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_idle", {30'd0, busy, cs_n}, 32'd1);
    check_regs();

    for (int k = 0; k < 40; k++) begin
      v.ini = ($urandom_range(0, 7) == 0);
      v.fmt = ($urandom_range(0, 7) == 0);
      v.wr  = ($urandom_range(0, 1) == 0);
      v.rd  = ($urandom_range(0, 1) == 0);
      if (!(v.ini || v.fmt || v.wr || v.rd)) v.rd = 1'b1;
      v.sel    = ($urandom_range(0, 5) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
      v.wdata  = 8'($urandom);
      v.rdbyte = 8'($urandom);
      run_vec(model(v));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
